// File: rtl/bcd7_pkg.sv
// bcd7_pkg: shared constants for the bcd7 scan/commit controller.
// Revision: 1.0
`default_nettype none

package bcd7_pkg;

  localparam logic [3:0] DIG0 = 4'b0001;
  localparam logic [3:0] DIG1 = 4'b0010;
  localparam logic [3:0] DIG2 = 4'b0100;
  localparam logic [3:0] DIG3 = 4'b1000;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_BLANK_LZ = 1;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_CTRL = 1'b1;

  function automatic logic [3:0] dig_onehot(input logic [1:0] idx);
    logic [3:0] sel;
    sel = DIG0;
    case (idx)
      2'd0:    sel = DIG0;
      2'd1:    sel = DIG1;
      2'd2:    sel = DIG2;
      default: sel = DIG3;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd7_scan_if.sv
// bcd7_scan_if: CPU write port and display-side outputs of the scan controller.
// Revision: 1.0
`default_nettype none

interface bcd7_scan_if;
  logic        wr_en;
  logic        wr_sel;
  logic [15:0] wr_data;
  logic [3:0]  an;
  logic        bcd7ctrl;
  logic [15:0] bcd7in;
  logic        busy;
  logic        frame_tick;

  modport master (
    output wr_en, wr_sel, wr_data,
    input  an, bcd7ctrl, bcd7in, busy, frame_tick
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    output an, bcd7ctrl, bcd7in, busy, frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/bcd7_prescaler.sv
// bcd7_prescaler: digit dwell counter, 0..SCAN_DIV-1, held at 0 while run is low.
// Revision: 1.0
`default_nettype none

module bcd7_prescaler #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = run && (cnt == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/bcd7_scan.sv
// bcd7_scan: 4-digit scan timing plus frame-aligned commit of buffered bus writes.
// Optional leading-zero blanking built when BCD7_SCAN_BLANK_EN is defined. Revision: 1.0
`default_nettype none

module bcd7_scan
  import bcd7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic        clk,
  input  logic        reset,
  bcd7_scan_if.slave  bus
);

  logic        en;
  logic [1:0]  idx;
  logic        tc;
  logic        pend;
  logic [15:0] pend_data;
  logic        data_wr;
  logic        ctrl_wr;
  logic        commit;
  logic        frame_tick;

  assign data_wr = bus.wr_en && (bus.wr_sel == SEL_DATA);
  assign ctrl_wr = bus.wr_en && (bus.wr_sel == SEL_CTRL);

  bcd7_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (en),
    .tc    (tc)
  );

  assign frame_tick = tc && (idx == 2'd3);
  // With scanning off there is nothing to tear, so commit immediately.
  assign commit     = pend && (frame_tick || !en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en        <= 1'b1;
      idx       <= 2'd0;
      pend      <= 1'b0;
      pend_data <= 16'h0000;
    end else begin
      if (ctrl_wr) begin
        en <= bus.wr_data[CTRL_EN];
      end
      if (!en) begin
        idx <= 2'd0;
      end else if (tc) begin
        idx <= idx + 2'd1;
      end
      if (data_wr) begin
        pend      <= 1'b1;
        pend_data <= bus.wr_data;
      end else if (commit) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef BCD7_SCAN_BLANK_EN
  logic        blank_lz;
  logic [15:0] shown;
  logic        lead_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_lz <= 1'b0;
      shown    <= 16'h0000;
    end else begin
      if (ctrl_wr) begin
        blank_lz <= bus.wr_data[CTRL_BLANK_LZ];
      end
      if (commit) begin
        shown <= pend_data;
      end
    end
  end

  // Digit k is a leading zero when it and every higher nibble are zero.
  always_comb begin
    lead_zero = 1'b0;
    case (idx)
      2'd1:    lead_zero = (shown[15:4]  == 12'd0);
      2'd2:    lead_zero = (shown[15:8]  == 8'd0);
      2'd3:    lead_zero = (shown[15:12] == 4'd0);
      default: lead_zero = 1'b0;
    endcase
  end

  assign bus.an = (en && !(blank_lz && lead_zero)) ? dig_onehot(idx) : 4'b0000;
`else
  assign bus.an = en ? dig_onehot(idx) : 4'b0000;
`endif

  assign bus.bcd7ctrl   = commit;
  assign bus.bcd7in     = pend_data;
  assign bus.busy       = pend;
  assign bus.frame_tick = frame_tick;

endmodule

`default_nettype wire
